// File: rtl/tile_packer_pkg.sv
// Shared types, geometry and header layout for the tile packer.
package tile_packer_pkg;

  localparam int unsigned ROWS      = 32;
  localparam int unsigned COLS      = 8;
  localparam int unsigned PIX_W     = 4;
  localparam int unsigned HDR_W     = 48;
  localparam int unsigned OUT_W     = 64;
  localparam int unsigned ROW_W     = COLS * PIX_W;
  localparam int unsigned RAW_WORDS = (ROWS * COLS * PIX_W) / OUT_W;
  localparam int unsigned IDX_W     = $clog2(RAW_WORDS);
  localparam int unsigned ROW_IDX_W = $clog2(ROWS);
  localparam int unsigned CNT_W     = 7;
  localparam int unsigned STAT_W    = 32;

  localparam logic [7:0]  MAGIC     = 8'hA5;
  localparam int unsigned MAGIC_LSB = 56;
  localparam int unsigned FLAG_BIT  = 55;
  localparam int unsigned CNT_LSB   = 48;

  typedef logic [ROWS-1:0][COLS-1:0][PIX_W-1:0] tile_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    RAW  = 2'd2
  } state_e;

  // Header word: magic, compressable flag, count of following words, core header.
  function automatic logic [OUT_W-1:0] make_hdr(input logic comp, input logic [HDR_W-1:0] hdr);
    logic [OUT_W-1:0] w;
    w                    = '0;
    w[MAGIC_LSB +: 8]    = MAGIC;
    w[FLAG_BIT]          = comp;
    w[CNT_LSB +: CNT_W]  = comp ? CNT_W'(0) : CNT_W'(RAW_WORDS);
    w[HDR_W-1:0]         = hdr;
    return w;
  endfunction

endpackage

// File: rtl/tile_packer.sv
// Serializes one captured tile into a header word plus optional raw payload words.
// Optional per-kind tile counters are built when TILE_PACKER_STATS_EN is defined.
module tile_packer
  import tile_packer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  tile_t            pixels,
  input  logic             compressable,
  input  logic [HDR_W-1:0] h,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
`ifdef TILE_PACKER_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_comp_cnt,
  output logic [STAT_W-1:0] stat_raw_cnt
`endif
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  tile_t              tile_q;
  logic               comp_q, comp_d;
  logic [HDR_W-1:0]   h_q, h_d;

  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [OUT_W-1:0]   out_data_q, out_data_d;
  logic               out_last_q, out_last_d;

  logic               accept;
  logic               out_hs;
  logic [ROW_IDX_W-1:0] row_lo, row_hi;

  assign accept = in_valid && in_ready_q;
  assign out_hs = out_valid_q && out_ready;

  // Next state, next capture and next registered outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    comp_d     = comp_q;
    h_d        = h_q;
    out_data_d = '0;
    out_last_d = 1'b0;
    row_lo     = '0;
    row_hi     = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HDR;
          comp_d  = compressable;
          h_d     = h;
        end
      end
      HDR: begin
        if (out_hs) begin
          state_d = comp_q ? IDLE : RAW;
          idx_d   = '0;
        end
      end
      RAW: begin
        if (out_hs) begin
          if (idx_q == IDX_W'(RAW_WORDS - 1)) begin
            state_d = IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are a function of where we land, so they register alongside the state.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d != IDLE);
    row_lo      = {idx_d, 1'b0};
    row_hi      = {idx_d, 1'b1};
    case (state_d)
      HDR: begin
        out_data_d = make_hdr(comp_d, h_d);
        out_last_d = comp_d;
      end
      RAW: begin
        out_data_d = {tile_q[row_hi], tile_q[row_lo]};
        out_last_d = (idx_d == IDX_W'(RAW_WORDS - 1));
      end
      default: begin
        out_data_d = '0;
        out_last_d = 1'b0;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      comp_q      <= 1'b0;
      h_q         <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      comp_q      <= comp_d;
      h_q         <= h_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // Payload capture needs no reset; it is only read after a fresh acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      tile_q <= pixels;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;

`ifdef TILE_PACKER_STATS_EN
  logic [STAT_W-1:0] comp_cnt_q, comp_cnt_d;
  logic [STAT_W-1:0] raw_cnt_q, raw_cnt_d;

  always_comb begin
    comp_cnt_d = comp_cnt_q;
    raw_cnt_d  = raw_cnt_q;
    if (accept) begin
      if (compressable) comp_cnt_d = comp_cnt_q + STAT_W'(1);
      else              raw_cnt_d  = raw_cnt_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      comp_cnt_q <= '0;
      raw_cnt_q  <= '0;
    end else begin
      comp_cnt_q <= comp_cnt_d;
      raw_cnt_q  <= raw_cnt_d;
    end
  end

  assign stat_comp_cnt = comp_cnt_q;
  assign stat_raw_cnt  = raw_cnt_q;
`endif

endmodule

// File: tb/tb_tile_packer.sv
// Directed self-checking bench for tile_packer; stats checks build with TILE_PACKER_STATS_EN.
module tb_tile_packer;
  import tile_packer_pkg::*;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  tile_t            pixels;
  logic             compressable;
  logic [HDR_W-1:0] h;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_last;
`ifdef TILE_PACKER_STATS_EN
  logic [31:0]      stat_comp_cnt;
  logic [31:0]      stat_raw_cnt;
`endif

  int checks = 0;
  int errors = 0;

  tile_packer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .pixels       (pixels),
    .compressable (compressable),
    .h            (h),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
`ifdef TILE_PACKER_STATS_EN
    ,
    .stat_comp_cnt(stat_comp_cnt),
    .stat_raw_cnt (stat_raw_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] row_a(input int r);
    logic [3:0] n;
    n = 4'(r);
    return {8{n}};
  endfunction

  function automatic logic [31:0] row_b(input int r);
    return 32'hC0DE_0000 | 32'(r * 3);
  endfunction

  // Expected header word built independently from the field layout.
  function automatic logic [63:0] hdr_word(input logic comp, input logic [47:0] hv);
    return {8'hA5, comp, comp ? 7'd0 : 7'd16, hv};
  endfunction

`ifdef TILE_PACKER_STATS_EN
  task automatic send_tile(input logic comp, input logic [47:0] hv);
    int budget;
    compressable = comp;
    h            = hv;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    budget   = 0;
    while (!(out_valid && out_last && out_ready) && budget < 40) begin
      step();
      budget++;
    end
    if (budget >= 40) chk("send_tile_timeout", 64'(budget), 64'd0);
    step();
  endtask
`endif

  logic [63:0] exp_w [17];

  initial begin
    int w;
    int cyc;
    logic [3:0] pat;

    rst          = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    compressable = 1'b0;
    h            = '0;
    pixels       = '0;
    step();
    step();
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data",  out_data,       64'd0);
    chk("rst_out_last",  64'(out_last),  64'd0);
`ifdef TILE_PACKER_STATS_EN
    chk("rst_stat_comp", 64'(stat_comp_cnt), 64'd0);
    chk("rst_stat_raw",  64'(stat_raw_cnt),  64'd0);
`endif
    rst = 1'b1;
    step();
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    // Compressable tile: single header word.
    compressable = 1'b1;
    h            = 48'h0123_4567_89AB;
    out_ready    = 1'b1;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk("comp_valid",    64'(out_valid), 64'd1);
    chk("comp_data",     out_data,       64'hA580_0123_4567_89AB);
    chk("comp_last",     64'(out_last),  64'd1);
    chk("comp_in_ready", 64'(in_ready),  64'd0);
    step();
    chk("comp_done_valid", 64'(out_valid), 64'd0);
    chk("comp_in_ready_back", 64'(in_ready), 64'd1);

    // Raw tile at full throughput.
    for (int r = 0; r < 32; r++) pixels[r] = row_a(r);
    compressable = 1'b0;
    h            = '0;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk("raw_hdr",      out_data,      64'hA510_0000_0000_0000);
    chk("raw_hdr_last", 64'(out_last), 64'd0);
    for (int k = 0; k < 16; k++) begin
      step();
      chk($sformatf("raw_w%0d", k), out_data, {row_a(2*k+1), row_a(2*k)});
      chk($sformatf("raw_last%0d", k), 64'(out_last), 64'(k == 15));
    end
    chk("raw_w0_literal_ref", {row_a(1), row_a(0)}, 64'h1111_1111_0000_0000);
    step();
    chk("raw_done_valid", 64'(out_valid), 64'd0);
    chk("raw_done_ready", 64'(in_ready),  64'd1);

    // Backpressure with out_ready pattern 1,0,0,1.
    for (int r = 0; r < 32; r++) pixels[r] = row_b(r);
    h        = 48'hBEEF_0000_CAFE;
    exp_w[0] = hdr_word(1'b0, 48'hBEEF_0000_CAFE);
    for (int k = 0; k < 16; k++) exp_w[k+1] = {row_b(2*k+1), row_b(2*k)};
    pat       = 4'b1001;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    w   = 0;
    cyc = 0;
    while (w < 17 && cyc < 200) begin
      chk($sformatf("bp_valid_c%0d", cyc), 64'(out_valid), 64'd1);
      chk($sformatf("bp_data_w%0d", w), out_data, exp_w[w]);
      chk($sformatf("bp_last_w%0d", w), 64'(out_last), 64'(w == 16));
      out_ready = pat[cyc % 4];
      step();
      if (out_ready) w++;
      cyc++;
    end
    if (cyc >= 200) chk("bp_timeout", 64'(w), 64'd17);
    out_ready = 1'b1;
    chk("bp_no_dup_valid", 64'(out_valid), 64'd0);
    step();

    // Second tile held valid while the first is busy.
    for (int r = 0; r < 32; r++) pixels[r] = row_a(r);
    compressable = 1'b0;
    h            = 48'h0000_0000_0001;
    in_valid     = 1'b1;
    step();
    compressable = 1'b1;
    h            = 48'h0000_0000_0002;
    chk("busy_first_hdr", out_data, 64'hA510_0000_0000_0001);
    for (int i = 0; i < 17; i++) begin
      chk($sformatf("busy_in_ready%0d", i), 64'(in_ready), 64'd0);
      step();
    end
    chk("busy_ready_after_last", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("busy_second_hdr",  out_data,      64'hA580_0000_0000_0002);
    chk("busy_second_last", 64'(out_last), 64'd1);
    step();
    chk("busy_second_done", 64'(out_valid), 64'd0);

    // Reset in the middle of raw word 5.
    compressable = 1'b0;
    h            = 48'h0000_0000_0033;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("mid_w5", out_data, {row_a(11), row_a(10)});
    rst = 1'b0;
    step();
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd0);
`ifdef TILE_PACKER_STATS_EN
    chk("mid_rst_stat_comp", 64'(stat_comp_cnt), 64'd0);
    chk("mid_rst_stat_raw",  64'(stat_raw_cnt),  64'd0);
`endif
    rst = 1'b1;
    step();
    chk("post_rst_ready", 64'(in_ready),  64'd1);
    chk("post_rst_valid", 64'(out_valid), 64'd0);
    compressable = 1'b1;
    h            = 48'h0000_00AB_CDEF;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    chk("post_rst_hdr",  out_data,      64'hA580_0000_00AB_CDEF);
    chk("post_rst_last", 64'(out_last), 64'd1);
    step();
    chk("post_rst_done", 64'(out_valid), 64'd0);

`ifdef TILE_PACKER_STATS_EN
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    chk("stat_zero_comp", 64'(stat_comp_cnt), 64'd0);
    chk("stat_zero_raw",  64'(stat_raw_cnt),  64'd0);
    send_tile(1'b1, 48'h1);
    send_tile(1'b0, 48'h2);
    send_tile(1'b1, 48'h3);
    send_tile(1'b0, 48'h4);
    send_tile(1'b1, 48'h5);
    chk("stat_comp_3", 64'(stat_comp_cnt), 64'd3);
    chk("stat_raw_2",  64'(stat_raw_cnt),  64'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
